// File: rtl/pc_seq.sv
// Program-counter sequencer: drives the instruction-fetch address and handles
// backpressure, stall, trap/redirect priority, misaligned targets and halt/resume.
module pc_seq #(
    parameter int unsigned   AW         = 32,
    parameter logic [AW-1:0] RESET_VEC  = '0,
    parameter logic [AW-1:0] TRAP_VEC   = AW'(32'h0000_0100),
    parameter int unsigned   STEP       = 4,
    parameter int unsigned   ALIGN_BITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_en,
    input  logic [AW-1:0] redirect_pc,
    input  logic          trap_en,
    input  logic          stall,
    input  logic          fetch_ready,
    input  logic          halt,
    input  logic          resume,
    output logic [AW-1:0] instr_addr,
    output logic          instr_fetch_en,
    output logic          halted,
    output logic          misalign_err,
    output logic          pc_wrap
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    state_t        state_r;
    logic [AW:0]   sum_s;

    // True when any of the low ALIGN_BITS bits of the target are set; ALIGN_BITS=0 never flags.
    function automatic logic is_misaligned(input logic [AW-1:0] pc);
        logic m;
        m = 1'b0;
        for (int i = 0; i < int'(AW); i++) begin
            if (i < int'(ALIGN_BITS)) begin
                m = m | pc[i];
            end
        end
        return m;
    endfunction

    // Extra top bit captures the carry out of the increment for the wrap flag.
    assign sum_s = {1'b0, instr_addr} + {1'b0, STEP_W};

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_BOOT;
            instr_addr     <= RESET_VEC;
            instr_fetch_en <= 1'b0;
            halted         <= 1'b0;
            misalign_err   <= 1'b0;
            pc_wrap        <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            pc_wrap      <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    instr_addr <= RESET_VEC;
                    if (halt) begin
                        state_r        <= ST_HALT;
                        instr_fetch_en <= 1'b0;
                        halted         <= 1'b1;
                    end else begin
                        state_r        <= ST_RUN;
                        instr_fetch_en <= 1'b1;
                        halted         <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Control-flow changes override stall and backpressure.
                    if (trap_en) begin
                        instr_addr     <= TRAP_VEC;
                        instr_fetch_en <= 1'b1;
                    end else if (redirect_en && !is_misaligned(redirect_pc)) begin
                        instr_addr     <= redirect_pc;
                        instr_fetch_en <= 1'b1;
                    end else if (redirect_en) begin
                        instr_addr     <= TRAP_VEC;
                        instr_fetch_en <= 1'b1;
                        misalign_err   <= 1'b1;
                    end else if (halt) begin
                        state_r        <= ST_HALT;
                        instr_fetch_en <= 1'b0;
                        halted         <= 1'b1;
                    end else if (stall || !fetch_ready) begin
                        instr_fetch_en <= 1'b1;
                    end else begin
                        instr_addr     <= sum_s[AW-1:0];
                        instr_fetch_en <= 1'b1;
                        pc_wrap        <= sum_s[AW];
                    end
                end
                ST_HALT: begin
                    if (trap_en) begin
                        state_r        <= ST_RUN;
                        instr_addr     <= TRAP_VEC;
                        instr_fetch_en <= 1'b1;
                        halted         <= 1'b0;
                    end else if (resume && !halt) begin
                        state_r        <= ST_RUN;
                        instr_fetch_en <= 1'b1;
                        halted         <= 1'b0;
                    end else begin
                        instr_fetch_en <= 1'b0;
                        halted         <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= ST_BOOT;
                    instr_addr     <= RESET_VEC;
                    instr_fetch_en <= 1'b0;
                    halted         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a vector table for the single-cycle behaviour plus
// hand-written sequences for wrap (AW=8 instance) and asynchronous reset.
module tb_pc_seq;

    logic        clk;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        trap_en;
    logic        stall;
    logic        fetch_ready;
    logic        halt;
    logic        resume;
    logic [31:0] instr_addr;
    logic        instr_fetch_en;
    logic        halted;
    logic        misalign_err;
    logic        pc_wrap;

    logic [7:0]  addr8;
    logic        fen8;
    logic        halted8;
    logic        mis8;
    logic        wrap8;

    int errors;
    int checks;

    typedef struct {
        logic        re;
        logic [31:0] rpc;
        logic        tr;
        logic        st;
        logic        fr;
        logic        h;
        logic        rs;
        logic [31:0] ea;
        logic        ef;
        logic        eh;
        logic        em;
        logic        ew;
    } vec_t;

    vec_t vecs[$];

    pc_seq dut (
        .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .trap_en(trap_en), .stall(stall), .fetch_ready(fetch_ready), .halt(halt),
        .resume(resume), .instr_addr(instr_addr), .instr_fetch_en(instr_fetch_en),
        .halted(halted), .misalign_err(misalign_err), .pc_wrap(pc_wrap)
    );

    pc_seq #(.AW(8), .TRAP_VEC(8'h80)) dut8 (
        .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_pc(redirect_pc[7:0]),
        .trap_en(trap_en), .stall(stall), .fetch_ready(fetch_ready), .halt(halt),
        .resume(resume), .instr_addr(addr8), .instr_fetch_en(fen8),
        .halted(halted8), .misalign_err(mis8), .pc_wrap(wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic re, input logic [31:0] rpc, input logic tr, input logic st,
                       input logic fr, input logic h, input logic rs, input logic [31:0] ea,
                       input logic ef, input logic eh, input logic em, input logic ew);
        vec_t v;
        v.re = re; v.rpc = rpc; v.tr = tr; v.st = st; v.fr = fr; v.h = h; v.rs = rs;
        v.ea = ea; v.ef = ef; v.eh = eh; v.em = em; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic re, input logic [31:0] rpc, input logic tr, input logic st,
                         input logic fr, input logic h, input logic rs);
        redirect_en = re; redirect_pc = rpc; trap_en = tr; stall = st;
        fetch_ready = fr; halt = h; resume = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [31:0] ea, input logic ef,
                              input logic eh, input logic em, input logic ew);
        check({tag, ".addr"}, instr_addr, ea);
        check({tag, ".fetch_en"}, {31'd0, instr_fetch_en}, {31'd0, ef});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
        check({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, em});
        check({tag, ".wrap"}, {31'd0, pc_wrap}, {31'd0, ew});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        //   re    rpc          tr    st    fr    h     rs    addr         fen   hlt   mis   wrap
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4,     1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8,     1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hC,     1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h14,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h14,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h12580, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12580, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h12580, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h12582, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100,   1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104,   1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 32'h40,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40,    1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40,    1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 32'h80,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40,    1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40,    1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44,    1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44,    1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100,   1'b1, 1'b0, 1'b0, 1'b0);

        step();
        step();
        check_main("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].re, vecs[i].rpc, vecs[i].tr, vecs[i].st, vecs[i].fr, vecs[i].h, vecs[i].rs);
            step();
            check_main($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ef, vecs[i].eh, vecs[i].em, vecs[i].ew);
        end

        // Wrap: both instances redirected to 0xFC; only the 8-bit one overflows.
        drive(1'b1, 32'hFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("wrap.pre8", {24'd0, addr8}, 32'hFC);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("wrap.addr8", {24'd0, addr8}, 32'h0);
        check("wrap.flag8", {31'd0, wrap8}, 32'd1);
        check_main("wrap.main", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("wrap.next8", {24'd0, addr8}, 32'h4);
        check("wrap.clear8", {31'd0, wrap8}, 32'd0);
        check("wrap.fen8", {31'd0, fen8}, 32'd1);

        // Async reset between edges, then boot straight into HALT.
        #3;
        rst = 1'b1;
        #1;
        check_main("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("async_rst.addr8", {24'd0, addr8}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_main("boot_halt", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("boot_halt.halted8", {31'd0, halted8}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check_main("boot_resume", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_main("boot_step", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        check("boot_step.mis8", {31'd0, mis8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
